reg_file_mp: RTL

Parametrised multi-port integer register file with an integrated pending-write scoreboard. It is the next-generation register bank for the pipelined RISC-V core and sits between decode (read and issue) and writeback. It provides NRD combinational read ports, NWR write ports and a per-register saturating pending counter, so decode can detect RAW hazards and stall on WAW overflow.

---
 rtl/rf_pkg.sv | 21 ++
 rtl/rf_scoreboard.sv | 67 ++++++
 rtl/reg_file_mp.sv | 73 +++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared types and constants for the multi-port register file and its
// pending-write scoreboard.
package rf_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned CNT_W     = 2;
  localparam int unsigned CNT_MAX   = 3;

  typedef logic [CNT_W-1:0] cnt_t;

  // Net issue/retire update, clamped to the counter range
  function automatic cnt_t cnt_update(cnt_t c, logic inc, int unsigned dec);
    int v;
    v = int'(c) + int'(inc) - int'(dec);
    if (v < 0) return '0;
    if (v > int'(CNT_MAX)) return cnt_t'(CNT_MAX);
    return cnt_t'(v);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register saturating pending-write counters, issue acceptance and busy
// lookup for the read ports. REG_FILE_BYPASS_EN makes busy see same-cycle retires.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter  int unsigned NREGS = NREGS_DEF,
  parameter  int unsigned NRD   = 2,
  parameter  int unsigned NWR   = 2,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]   rd_busy,
  input  logic [NWR-1:0]   wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic [NWR-1:0]   wr_retire,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  output logic             iss_ready,
  input  logic             flush
);

  cnt_t        r_cnt     [NREGS];
  cnt_t        w_cnt_nxt [NREGS];
  int unsigned w_dec     [NREGS];
  logic        w_inc     [NREGS];

  assign iss_ready = (r_cnt[iss_rd] != cnt_t'(CNT_MAX)) || (iss_rd == '0);

  always_comb begin
    for (int unsigned r = 0; r < NREGS; r++) begin
      w_dec[r] = 0;
      for (int unsigned p = 0; p < NWR; p++) begin
        if (wr_en[p] && wr_retire[p] && (wr_addr[p*AW +: AW] == AW'(r)))
          w_dec[r] += 1;
      end
      w_inc[r]     = iss_valid && iss_ready && (iss_rd == AW'(r));
      w_cnt_nxt[r] = (r == 0) ? '0 : cnt_update(r_cnt[r], w_inc[r], w_dec[r]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREGS; r++) r_cnt[r] <= '0;
    end else if (flush) begin
      for (int unsigned r = 0; r < NREGS; r++) r_cnt[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) r_cnt[r] <= w_cnt_nxt[r];
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
`ifdef REG_FILE_BYPASS_EN
      // A retire that drains the counter this cycle already reads as not busy
      rd_busy[k] = (r_cnt[rd_addr[k*AW +: AW]] != '0) &&
                   !((w_dec[rd_addr[k*AW +: AW]] != 0) &&
                     (w_cnt_nxt[rd_addr[k*AW +: AW]] == '0));
`else
      rd_busy[k] = (r_cnt[rd_addr[k*AW +: AW]] != '0);
`endif
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with pending-write scoreboard.
// Define REG_FILE_BYPASS_EN to forward same-cycle writes onto the read ports.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter  int unsigned XLEN  = XLEN_DEF,
  parameter  int unsigned NREGS = NREGS_DEF,
  parameter  int unsigned NRD   = 2,
  parameter  int unsigned NWR   = 2,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [NWR-1:0]      wr_retire,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic                iss_ready,
  input  logic                flush
);

  logic [XLEN-1:0] r_regs [NREGS];

  // Later ports are applied last, so the highest index wins a collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREGS; r++) r_regs[r] <= '0;
    end else begin
      for (int unsigned p = 0; p < NWR; p++) begin
        if (wr_en[p] && (wr_addr[p*AW +: AW] != '0))
          r_regs[wr_addr[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      rd_data[k*XLEN +: XLEN] = r_regs[rd_addr[k*AW +: AW]];
`ifdef REG_FILE_BYPASS_EN
      for (int unsigned p = 0; p < NWR; p++) begin
        if (wr_en[p] && (wr_addr[p*AW +: AW] == rd_addr[k*AW +: AW]) &&
            (rd_addr[k*AW +: AW] != '0))
          rd_data[k*XLEN +: XLEN] = wr_data[p*XLEN +: XLEN];
      end
`endif
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_retire (wr_retire),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .flush     (flush)
  );

endmodule
